// File: rtl/miner_pkg.sv
// Shared types and constants for the miner nonce scheduler.
// Holds the scheduler state encoding and the default nonce width.
package miner_pkg;

  localparam int NONCE_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

endpackage

// File: rtl/miner_scheduler_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// The pointer moves to one past the granted index whenever advance is high.
module rr_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] req,
  input  logic         advance,
  output logic [W-1:0] grant
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;
  logic [PW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // first requester at or after the pointer wins
  always_comb begin
    grant     = '0;
    ptr_nxt_s = ptr_r;
    idx_s     = '0;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    for (int k = 0; k < W; k++) begin
      idx_s        = PW'((int'(ptr_r) + k) % W);
      hit_s        = req[idx_s] & ~found_s;
      grant[idx_s] = grant[idx_s] | hit_s;
      ptr_nxt_s    = hit_s ? PW'((int'(idx_s) + 1) % W) : ptr_nxt_s;
      found_s      = found_s | hit_s;
    end
  end

  // pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= ptr_nxt_s;
    end
  end

endmodule

// File: rtl/miner_scheduler.sv
// Hands sequential nonces to idle hash cores and collects winning nonces,
// signalling completion once every core is idle and all results are drained.
module miner_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int NONCE_W      = NONCE_W_DEF,
  parameter bit STOP_ON_FIND = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NONCE_W-1:0]           nonce_start,
  input  logic [NONCE_W-1:0]           nonce_end,
  input  logic [NUM_CORES-1:0]         core_ready,
  output logic [NUM_CORES-1:0]         core_req,
  output logic [NONCE_W-1:0]           core_nonce,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_found_nonce,
  output logic [NUM_CORES-1:0]         core_found_ack,
  output logic                         found_valid,
  output logic [NONCE_W-1:0]           found_nonce,
  input  logic                         found_ready,
  output logic                         busy,
  output logic                         done
);

  state_t               state_r, state_nxt_s;
  logic [NONCE_W-1:0]   next_r, last_r;
  logic [NONCE_W-1:0]   found_nonce_r, cap_nonce_s;
  logic [NUM_CORES-1:0] iss_grant_s, find_req_s, find_grant_s, core_found_ack_r;
  logic                 found_valid_r, done_r, busy_r;
  logic                 can_capture_s, capture_s, issue_s;
  logic                 load_s, empty_done_s, drain_done_s;

  // a core whose ack is in flight is masked so it is not captured twice
  assign can_capture_s = ~found_valid_r | found_ready;
  assign find_req_s    = can_capture_s ? (core_found & ~core_found_ack_r) : '0;
  assign capture_s     = |find_grant_s;
  assign issue_s       = |core_req;

  rr_arbiter #(.W(NUM_CORES)) u_issue_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (core_ready),
    .advance (issue_s),
    .grant   (iss_grant_s)
  );

  rr_arbiter #(.W(NUM_CORES)) u_find_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (find_req_s),
    .advance (capture_s),
    .grant   (find_grant_s)
  );

  // one-hot select of the captured core's nonce
  always_comb begin
    cap_nonce_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cap_nonce_s = cap_nonce_s |
                    ({NONCE_W{find_grant_s[i]}} & core_found_nonce[i*NONCE_W +: NONCE_W]);
    end
  end

  // next-state and issue decode
  always_comb begin
    state_nxt_s  = state_r;
    core_req     = '0;
    load_s       = 1'b0;
    empty_done_s = 1'b0;
    drain_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (nonce_start <= nonce_end)) begin
          state_nxt_s = ST_DISPATCH;
          load_s      = 1'b1;
        end else if (start) begin
          empty_done_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if (abort) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          core_req = iss_grant_s;
          if (((|iss_grant_s) && (next_r == last_r)) || (STOP_ON_FIND && capture_s)) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_DISPATCH;
          end
        end
      end
      ST_DRAIN: begin
        if ((&core_ready) && !found_valid_r && !(|core_found)) begin
          state_nxt_s  = ST_IDLE;
          drain_done_s = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // nonce counter, result register and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_r           <= '0;
      last_r           <= '0;
      found_valid_r    <= 1'b0;
      found_nonce_r    <= '0;
      core_found_ack_r <= '0;
      done_r           <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      if (load_s) begin
        next_r <= nonce_start;
        last_r <= nonce_end;
      end else if (issue_s && (next_r != last_r)) begin
        next_r <= next_r + NONCE_W'(1);
      end
      if (capture_s) begin
        found_valid_r <= 1'b1;
        found_nonce_r <= cap_nonce_s;
      end else if (found_ready) begin
        found_valid_r <= 1'b0;
      end
      core_found_ack_r <= find_grant_s;
      done_r           <= empty_done_s | drain_done_s;
      busy_r           <= (state_nxt_s != ST_IDLE);
    end
  end

  assign core_nonce     = next_r;
  assign core_found_ack = core_found_ack_r;
  assign found_valid    = found_valid_r;
  assign found_nonce    = found_nonce_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_miner_scheduler.sv
// Scoreboard bench for miner_scheduler: stimulus queues expected issues,
// acks and done pulses with their cycle numbers; a monitor pops and compares.
module tb_miner_scheduler;

  localparam int NC = 4;
  localparam int NW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, abort, found_ready;
  logic [NW-1:0]    nonce_start, nonce_end;
  logic [NC-1:0]    core_ready, core_req, core_found, core_found_ack;
  logic [NW-1:0]    core_nonce, found_nonce;
  logic [NC*NW-1:0] core_found_nonce;
  logic             found_valid, busy, done;

  miner_scheduler #(.NUM_CORES(NC), .NONCE_W(NW), .STOP_ON_FIND(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .nonce_start      (nonce_start),
    .nonce_end        (nonce_end),
    .core_ready       (core_ready),
    .core_req         (core_req),
    .core_nonce       (core_nonce),
    .core_found       (core_found),
    .core_found_nonce (core_found_nonce),
    .core_found_ack   (core_found_ack),
    .found_valid      (found_valid),
    .found_nonce      (found_nonce),
    .found_ready      (found_ready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [NC-1:0] v;
    logic [NW-1:0] n;
  } ev_t;

  ev_t iss_q[$];
  ev_t ack_q[$];
  int  done_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_issue(input int c, input logic [NC-1:0] v, input logic [NW-1:0] n);
    ev_t e;
    e.c = c; e.v = v; e.n = n;
    iss_q.push_back(e);
  endtask

  task automatic exp_ack(input int c, input logic [NC-1:0] v, input logic [NW-1:0] n);
    ev_t e;
    e.c = c; e.v = v; e.n = n;
    ack_q.push_back(e);
  endtask

  // monitor: compare every DUT-presented event against the scoreboard
  always @(negedge clk) begin : mon
    ev_t e;
    int  dc;
    if (reset) begin
      if (|(core_req & core_ready)) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", 1'b0, {16'(cyc), 16'(core_req), core_nonce}, 64'd0);
        end else begin
          e = iss_q.pop_front();
          chk("issue", (cyc == e.c) && (core_req == e.v) && (core_nonce == e.n),
              {16'(cyc), 16'(core_req), core_nonce}, {16'(e.c), 16'(e.v), e.n});
        end
      end
      if (|core_found_ack) begin
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", 1'b0, {16'(cyc), 16'(core_found_ack), found_nonce}, 64'd0);
        end else begin
          e = ack_q.pop_front();
          chk("ack", (cyc == e.c) && (core_found_ack == e.v) && (found_nonce == e.n) && found_valid,
              {16'(cyc), 16'(core_found_ack), found_nonce}, {16'(e.c), 16'(e.v), e.n});
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1'b0, 64'(cyc), 64'd0);
        end else begin
          dc = done_q.pop_front();
          chk("done", (cyc == dc) && !busy, {32'(busy), 32'(cyc)}, {32'd0, 32'(dc)});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; start = 1'b0; abort = 1'b0; found_ready = 1'b0;
    nonce_start = '0; nonce_end = '0;
    core_ready = 4'b1111; core_found = 4'b0000; core_found_nonce = '0;
    tick(2);
    chk("reset_ctrl", {core_req, core_found_ack, found_valid, done, busy} == 11'd0,
        64'({core_req, core_found_ack, found_valid, done, busy}), 64'd0);
    chk("reset_data", {found_nonce, core_nonce} == 64'd0, {found_nonce, core_nonce}, 64'd0);
    reset = 1'b1;
    tick(1);

    // range 0x10..0x13, all cores ready
    k = cyc;
    start = 1'b1; nonce_start = 32'h10; nonce_end = 32'h13;
    for (int i = 0; i < 4; i++) exp_issue(k + 1 + i, 4'(4'b0001 << i), 32'h10 + 32'(i));
    done_q.push_back(k + 6);
    tick(1);
    start = 1'b0;
    chk("busy_after_start", busy == 1'b1, 64'(busy), 64'd1);
    tick(7);

    // top of nonce space, only core 0 ready
    k = cyc;
    start = 1'b1; nonce_start = 32'hFFFF_FFFE; nonce_end = 32'hFFFF_FFFF; core_ready = 4'b0001;
    exp_issue(k + 1, 4'b0001, 32'hFFFF_FFFE);
    exp_issue(k + 2, 4'b0001, 32'hFFFF_FFFF);
    done_q.push_back(k + 4);
    tick(1);
    start = 1'b0;
    tick(2);
    core_ready = 4'b1111;
    tick(3);

    // empty range
    k = cyc;
    start = 1'b1; nonce_start = 32'd5; nonce_end = 32'd3;
    done_q.push_back(k + 1);
    tick(1);
    start = 1'b0;
    chk("empty_busy0", busy == 1'b0, 64'(busy), 64'd0);
    tick(1);
    chk("empty_busy1", busy == 1'b0, 64'(busy), 64'd0);
    tick(1);

    // simultaneous finds on cores 0 and 3, consumer stalled
    k = cyc;
    core_found_nonce = {32'h3333_0003, 32'h0, 32'h0, 32'hAAAA_0000};
    core_found = 4'b1001;
    exp_ack(k + 1, 4'b0001, 32'hAAAA_0000);
    tick(1);
    core_found = 4'b1000;
    tick(1);
    chk("find_blocked", found_valid && (found_nonce == 32'hAAAA_0000),
        {31'd0, found_valid, found_nonce}, {31'd0, 1'b1, 32'hAAAA_0000});
    tick(1);
    found_ready = 1'b1;
    exp_ack(k + 4, 4'b1000, 32'h3333_0003);
    tick(1);
    found_ready = 1'b0; core_found = 4'b0000;
    tick(1);
    found_ready = 1'b1;
    tick(1);
    found_ready = 1'b0;
    chk("find_consumed", found_valid == 1'b0, 64'(found_valid), 64'd0);
    tick(1);

    // stop on find: core 2 reports 0x1234 mid-range
    k = cyc;
    start = 1'b1; nonce_start = 32'h100; nonce_end = 32'h1FF;
    exp_issue(k + 1, 4'b0010, 32'h100);
    exp_issue(k + 2, 4'b0100, 32'h101);
    exp_issue(k + 3, 4'b1000, 32'h102);
    tick(1);
    start = 1'b0;
    tick(2);
    core_found_nonce = {32'h0, 32'h1234, 32'h0, 32'h0};
    core_found = 4'b0100;
    exp_ack(k + 4, 4'b0100, 32'h1234);
    tick(1);
    core_found = 4'b0000;
    tick(3);
    chk("stop_wait_valid", found_valid == 1'b1, 64'(found_valid), 64'd1);
    chk("stop_wait_busy", busy == 1'b1, 64'(busy), 64'd1);
    found_ready = 1'b1;
    done_q.push_back(k + 9);
    tick(1);
    found_ready = 1'b0;
    tick(3);

    // abort at nonce 0x40 of 0x0..0xFF
    k = cyc;
    start = 1'b1; nonce_start = 32'h0; nonce_end = 32'hFF;
    for (int n = 0; n < 64; n++) exp_issue(k + 1 + n, 4'(4'b0001 << (n % 4)), 32'(n));
    tick(1);
    start = 1'b0;
    tick(64);
    abort = 1'b1; core_ready = 4'b0101;
    tick(1);
    abort = 1'b0;
    tick(3);
    chk("abort_drain_busy", busy == 1'b1, 64'(busy), 64'd1);
    tick(1);
    core_ready = 4'b1111;
    done_q.push_back(k + 71);
    tick(3);

    // reset in the middle of a job
    k = cyc;
    start = 1'b1; nonce_start = 32'h0; nonce_end = 32'hFF;
    exp_issue(k + 1, 4'b0001, 32'h0);
    tick(1);
    start = 1'b0;
    core_found_nonce = {32'h0, 32'h0, 32'h77, 32'h0};
    core_found = 4'b0010;
    exp_ack(k + 2, 4'b0010, 32'h77);
    tick(1);
    core_found = 4'b0000;
    chk("pre_reset_busy", busy && found_valid, {62'd0, busy, found_valid}, 64'd3);
    tick(1);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_ctrl", {core_req, core_found_ack, found_valid, done, busy} == 11'd0,
        64'({core_req, core_found_ack, found_valid, done, busy}), 64'd0);
    chk("midreset_data", {found_nonce, core_nonce} == 64'd0, {found_nonce, core_nonce}, 64'd0);
    tick(2);
    reset = 1'b1;
    tick(2);

    chk("issue_q_empty", iss_q.size() == 0, 64'(iss_q.size()), 64'd0);
    chk("ack_q_empty", ack_q.size() == 0, 64'(ack_q.size()), 64'd0);
    chk("done_q_empty", done_q.size() == 0, 64'(done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
